// File: rtl/sram_rd_stream.sv
// Read-side burst engine for one sram bank: turns (addr, len) requests into per-word sram reads
// and delivers the returned words as a valid/ready stream with a per-burst last flag.
module sram_rd_stream #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_rd_addr,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                s1_last_q, s1_last_d;
  logic                s2_valid_q, s2_valid_d;
  logic                s2_last_q, s2_last_d;
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [CNT_W:0]      occupancy;
  logic                credit_ok;
  logic                accept;
  logic                issue;
  logic                issue_last;
  logic [ADDR_W-1:0]   issue_addr;
  logic                push;
  logic                pop;

  // Every read already issued (stage1 = rd_en cycle, stage2 = dout cycle) owns a FIFO slot,
  // so a push can never land on a full FIFO.
  assign occupancy = {1'b0, count_q} + (CNT_W+1)'(rd_en_q) + (CNT_W+1)'(s2_valid_q);
  assign credit_ok = occupancy < (CNT_W+1)'(FIFO_DEPTH);

  assign req_ready = rst_n && (state_q == S_IDLE) && credit_ok;
  assign accept    = req_valid && req_ready;

  assign out_valid = (count_q != '0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_last  = fifo_last_q[rd_ptr_q];
  assign push      = s2_valid_q;
  assign pop       = out_valid && out_ready;

  assign sram_rd_en   = rd_en_q;
  assign sram_rd_addr = rd_addr_q;

  // The accept cycle issues the first word itself, giving rd_en one cycle after accept.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = cur_addr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          issue      = 1'b1;
          issue_addr = req_addr;
          issue_last = (req_len == '0);
          cur_addr_d = req_addr + ADDR_W'(1);
          remain_d   = req_len - LEN_W'(1);
          if (req_len != '0) state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (remain_q == '0);
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          remain_d   = remain_q - LEN_W'(1);
          if (remain_q == '0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en_d    = issue;
    rd_addr_d  = issue ? issue_addr : rd_addr_q;
    s1_last_d  = issue && issue_last;
    s2_valid_d = rd_en_q;
    s2_last_d  = s1_last_q;

    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = sram_dout;
      fifo_last_d[wr_ptr_q] = s2_last_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remain_q    <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      fifo_data_q <= '{default: '0};
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remain_q    <= remain_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_sram_rd_stream.sv
// Directed bench for sram_rd_stream: behavioural sram with 1-cycle read latency, monitors that log
// read pulses and popped words per cycle, and hand-computed expectations per scenario.
module tb_sram_rd_stream;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [13:0] req_addr;
  logic [9:0]  req_len;
  logic        sram_rd_en;
  logic [13:0] sram_rd_addr;
  logic [15:0] sram_dout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct { int cyc; logic [13:0] addr; } rd_rec_t;
  typedef struct { int cyc; logic [15:0] data; logic last; } out_rec_t;
  rd_rec_t  rd_q[$];
  out_rec_t out_q[$];

  sram_rd_stream dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_dout(sram_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  function automatic logic [15:0] word(input logic [13:0] a);
    return {2'b01, a} ^ 16'h5A3C;
  endfunction

  initial sram_dout = '0;
  always @(posedge clk) if (sram_rd_en) sram_dout <= word(sram_rd_addr);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sram_rd_en) rd_q.push_back('{cyc, sram_rd_addr});
    if (out_valid && out_ready) out_q.push_back('{cyc, out_data, out_last});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    rd_q.delete();
    out_q.delete();
  endtask

  task automatic issue_req(input logic [13:0] a, input logic [9:0] l, output int t);
    bit ok;
    ok = 1'b0;
    t  = -1;
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (req_ready) begin
        t  = cyc;
        ok = 1'b1;
      end
      tick();
    end
    req_valid = 1'b0;
    req_addr  = 14'($urandom);
    req_len   = 10'($urandom);
    chk("req_accept", 32'(ok), 32'd1);
  endtask

  task automatic check_burst(input string pfx, input int t, input logic [13:0] base,
                             input int n, input bit timed);
    logic [13:0] a;
    chk({pfx, "_rd_cnt"}, 32'(rd_q.size()), 32'(n));
    chk({pfx, "_out_cnt"}, 32'(out_q.size()), 32'(n));
    for (int i = 0; i < n && i < rd_q.size(); i++) begin
      a = base + 14'(i);
      chk({pfx, "_rd_addr"}, 32'(rd_q[i].addr), 32'(a));
      if (timed) chk({pfx, "_rd_cyc"}, 32'(rd_q[i].cyc), 32'(t + 1 + i));
    end
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      a = base + 14'(i);
      chk({pfx, "_data"}, 32'(out_q[i].data), 32'(word(a)));
      chk({pfx, "_last"}, 32'(out_q[i].last), 32'(i == n - 1));
      if (timed) chk({pfx, "_out_cyc"}, 32'(out_q[i].cyc), 32'(t + 3 + i));
    end
  endtask

  int          t;
  int          t1;
  int          t2;
  logic [13:0] exp_addr [5];
  logic        exp_last [5];

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    out_ready = 1'b0;
    repeat (3) tick();

    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rd_en", 32'(sram_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(sram_rd_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // single-word burst
    out_ready = 1'b1;
    clear_logs();
    issue_req(14'd5, 10'd0, t);
    repeat (8) tick();
    check_burst("s1", t, 14'd5, 1, 1'b1);

    // 8-word burst at full throughput
    clear_logs();
    issue_req(14'd100, 10'd7, t);
    repeat (14) tick();
    check_burst("s2", t, 14'd100, 8, 1'b1);

    // credit stall with consumer blocked, then drain
    out_ready = 1'b0;
    clear_logs();
    issue_req(14'd200, 10'd15, t);
    repeat (10) tick();
    chk("s3_stall_rd_cnt", 32'(rd_q.size()), 32'd4);
    chk("s3_stall_out_valid", 32'(out_valid), 32'd1);
    chk("s3_stall_hold_data", 32'(out_data), 32'(word(14'd200)));
    chk("s3_stall_hold_last", 32'(out_last), 32'd0);
    out_ready = 1'b1;
    repeat (30) tick();
    check_burst("s3", t, 14'd200, 16, 1'b0);

    // address wrap at the top of the sram
    clear_logs();
    issue_req(14'd16382, 10'd3, t);
    repeat (10) tick();
    check_burst("s4", t, 14'd16382, 4, 1'b1);
    if (rd_q.size() == 4) chk("s4_wrap_addr", 32'(rd_q[2].addr), 32'd0);

    // back-to-back bursts
    exp_addr = '{14'd300, 14'd301, 14'd302, 14'd400, 14'd401};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    clear_logs();
    issue_req(14'd300, 10'd2, t1);
    issue_req(14'd400, 10'd1, t2);
    repeat (10) tick();
    chk("s5_second_accept", 32'(t2), 32'(t1 + 3));
    chk("s5_rd_cnt", 32'(rd_q.size()), 32'd5);
    chk("s5_out_cnt", 32'(out_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < rd_q.size(); i++) begin
      chk("s5_rd_addr", 32'(rd_q[i].addr), 32'(exp_addr[i]));
      chk("s5_rd_cyc", 32'(rd_q[i].cyc), 32'(t1 + 1 + i));
    end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      chk("s5_data", 32'(out_q[i].data), 32'(word(exp_addr[i])));
      chk("s5_last", 32'(out_q[i].last), 32'(exp_last[i]));
      chk("s5_out_cyc", 32'(out_q[i].cyc), 32'(t1 + 3 + i));
    end

    // reset mid-burst: 2 words in FIFO, reads still in flight
    out_ready = 1'b0;
    clear_logs();
    issue_req(14'd500, 10'd7, t);
    repeat (3) tick();
    chk("s6_pre_out_valid", 32'(out_valid), 32'd1);
    chk("s6_pre_rd_en", 32'(sram_rd_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_rd_en", 32'(sram_rd_en), 32'd0);
    chk("s6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("s6_rst_out_data", 32'(out_data), 32'd0);
    chk("s6_rst_req_ready", 32'(req_ready), 32'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    clear_logs();
    issue_req(14'd5, 10'd0, t);
    repeat (10) tick();
    check_burst("s6", t, 14'd5, 1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
